// File: rtl/otter_pipe_pkg.sv
// Shared pipeline types for the OTTER core: scoreboard entries, forwarding selections
// and the base opcode map used by decode to derive de_is_load / de_reg_write.
package otter_pipe_pkg;

    // Register addresses are zero-extended into a fixed-width field so the struct stays
    // parameter-free; RA_W of the instantiating block must not exceed RA_MAX.
    localparam int RA_MAX = 8;
    localparam int IDX_W  = 3;

    typedef struct packed {
        logic              valid;
        logic [RA_MAX-1:0] rd;
        logic              is_load;
    } sb_entry_t;

    typedef struct packed {
        logic             hit;
        logic             available;
        logic [IDX_W-1:0] index;
    } fwd_sel_t;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    function automatic logic opIsLoad(input opcode_t op);
        return op == OP_LOAD;
    endfunction

    function automatic logic opWritesRd(input opcode_t op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_IMM, OP_REG, OP_SYSTEM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic opReadsRs1(input opcode_t op);
        case (op)
            OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
            OP_IMM, OP_REG, OP_SYSTEM: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic opReadsRs2(input opcode_t op);
        case (op)
            OP_BRANCH, OP_STORE, OP_REG: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/otter_fwd_select.sv
// Priority match of one source operand against the in-flight scoreboard; the youngest
// (lowest-index) matching entry wins.
module otter_fwd_select
    import otter_pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int RA_W       = 5,
    parameter int LOAD_STAGE = 2
) (
    input  sb_entry_t [DEPTH-1:0] sb_i,
    input  logic [RA_W-1:0]       rs_addr_i,
    input  logic                  rs_used_i,
    output fwd_sel_t              sel_o
);

    logic [RA_MAX-1:0] rsExt;

    assign rsExt = RA_MAX'(rs_addr_i);

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        sel_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sb_i[i].valid && rs_used_i && (rsExt != '0) && (sb_i[i].rd == rsExt)) begin
                sel_o.hit       = 1'b1;
                sel_o.available = !sb_i[i].is_load || (i >= LOAD_STAGE);
                sel_o.index     = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Hazard, forwarding and flush controller beside decode: tracks in-flight destinations,
// picks bypass sources, raises load-use stalls, redirect flushes and memory freezes.
module otter_hazard_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  de_valid,
    input  logic [RA_W-1:0]       de_rs1_addr,
    input  logic [RA_W-1:0]       de_rs2_addr,
    input  logic                  de_rs1_used,
    input  logic                  de_rs2_used,
    input  logic [RA_W-1:0]       de_rd_addr,
    input  logic                  de_reg_write,
    input  logic                  de_is_load,
    input  logic [XLEN-1:0]       de_rs1_rf,
    input  logic [XLEN-1:0]       de_rs2_rf,
    input  logic [DEPTH*XLEN-1:0] st_result,
    input  logic                  ex_redirect,
    input  logic                  mem_ready,
    output logic [XLEN-1:0]       rs1_val,
    output logic [XLEN-1:0]       rs2_val,
    output logic                  stall,
    output logic                  freeze,
    output logic                  flush_if,
    output logic                  flush_de,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]      stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]      flushCnt_q, flushCnt_d;
    fwd_sel_t              sel1, sel2;
    logic                  loadUse;

    otter_fwd_select #(
        .DEPTH      (DEPTH),
        .RA_W       (RA_W),
        .LOAD_STAGE (LOAD_STAGE)
    ) u_sel_rs1 (
        .sb_i      (sb_q),
        .rs_addr_i (de_rs1_addr),
        .rs_used_i (de_rs1_used),
        .sel_o     (sel1)
    );

    otter_fwd_select #(
        .DEPTH      (DEPTH),
        .RA_W       (RA_W),
        .LOAD_STAGE (LOAD_STAGE)
    ) u_sel_rs2 (
        .sb_i      (sb_q),
        .rs_addr_i (de_rs2_addr),
        .rs_used_i (de_rs2_used),
        .sel_o     (sel2)
    );

    // An unavailable youngest match means the load data is not yet in st_result.
    assign loadUse = de_valid && ((sel1.hit && !sel1.available) ||
                                  (sel2.hit && !sel2.available));

    always_comb begin
        rs1_val = de_rs1_rf;
        rs2_val = de_rs2_rf;
        if (sel1.hit && sel1.available) begin
            rs1_val = st_result[int'(sel1.index)*XLEN +: XLEN];
        end
        if (sel2.hit && sel2.available) begin
            rs2_val = st_result[int'(sel2.index)*XLEN +: XLEN];
        end
    end

    // A frozen cycle never flushes: EX keeps the redirect until memory releases.
    always_comb begin
        freeze   = 1'b0;
        stall    = 1'b0;
        flush_if = 1'b0;
        flush_de = 1'b0;
        if (!RST) begin
            if (!mem_ready) begin
                freeze = 1'b1;
                stall  = 1'b1;
            end else if (ex_redirect) begin
                flush_if = 1'b1;
                flush_de = 1'b1;
            end else if (loadUse) begin
                stall = 1'b1;
            end
        end
    end

    always_comb begin
        sb_d = sb_q;
        if (!freeze) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                sb_d[i] = sb_q[i-1];
            end
            if (ex_redirect || loadUse) begin
                sb_d[0] = '0;
            end else begin
                sb_d[0].valid   = de_valid & de_reg_write;
                sb_d[0].rd      = RA_MAX'(de_rd_addr);
                sb_d[0].is_load = de_is_load;
            end
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (stall && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
        if (flush_de && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sb_q       <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            sb_q       <= sb_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl: a table of per-cycle vectors plus hand-written
// redirect, freeze, reset and counter-saturation sequences.
module tb_otter_hazard_ctrl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 3;

    localparam logic [31:0] RF1 = 32'hAAAA0001;
    localparam logic [31:0] RF2 = 32'hBBBB0002;
    localparam logic [31:0] S0  = 32'h00000011;
    localparam logic [31:0] S1  = 32'h00002222;
    localparam logic [31:0] S2  = 32'hDEADBEEF;

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        redir;
        logic        rdy;
        logic [31:0] expRs1;
        logic [31:0] expRs2;
        logic        expStall;
        logic        expFreeze;
        logic        expFlush;
    } vec_t;

    logic                  CLK;
    logic                  RST;
    logic                  deValid;
    logic [4:0]            deRs1Addr, deRs2Addr, deRdAddr;
    logic                  deRs1Used, deRs2Used, deRegWrite, deIsLoad;
    logic [XLEN-1:0]       deRs1Rf, deRs2Rf;
    logic [DEPTH*XLEN-1:0] stResult;
    logic                  exRedirect, memReady;

    logic [XLEN-1:0] rs1Val, rs2Val, rs1Val4, rs2Val4;
    logic            stall, freeze, flushIf, flushDe;
    logic            stall4, freeze4, flushIf4, flushDe4;
    logic [31:0]     stallCnt, flushCnt;
    logic [3:0]      stallCnt4, flushCnt4;

    int checks = 0;
    int errors = 0;
    vec_t vecs[11];

    otter_hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .de_valid(deValid),
        .de_rs1_addr(deRs1Addr), .de_rs2_addr(deRs2Addr),
        .de_rs1_used(deRs1Used), .de_rs2_used(deRs2Used),
        .de_rd_addr(deRdAddr), .de_reg_write(deRegWrite), .de_is_load(deIsLoad),
        .de_rs1_rf(deRs1Rf), .de_rs2_rf(deRs2Rf), .st_result(stResult),
        .ex_redirect(exRedirect), .mem_ready(memReady),
        .rs1_val(rs1Val), .rs2_val(rs2Val), .stall(stall), .freeze(freeze),
        .flush_if(flushIf), .flush_de(flushDe),
        .stall_cnt(stallCnt), .flush_cnt(flushCnt)
    );

    otter_hazard_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .de_valid(deValid),
        .de_rs1_addr(deRs1Addr), .de_rs2_addr(deRs2Addr),
        .de_rs1_used(deRs1Used), .de_rs2_used(deRs2Used),
        .de_rd_addr(deRdAddr), .de_reg_write(deRegWrite), .de_is_load(deIsLoad),
        .de_rs1_rf(deRs1Rf), .de_rs2_rf(deRs2Rf), .st_result(stResult),
        .ex_redirect(exRedirect), .mem_ready(memReady),
        .rs1_val(rs1Val4), .rs2_val(rs2Val4), .stall(stall4), .freeze(freeze4),
        .flush_if(flushIf4), .flush_de(flushDe4),
        .stall_cnt(stallCnt4), .flush_cnt(flushCnt4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic ld, input logic redir,
                                input logic rdy, input logic [31:0] e1, input logic [31:0] e2,
                                input logic st, input logic fr, input logic fl);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd;
        r.rw = rw; r.ld = ld; r.redir = redir; r.rdy = rdy;
        r.expRs1 = e1; r.expRs2 = e2; r.expStall = st; r.expFreeze = fr; r.expFlush = fl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        deValid    = v.v;
        deRs1Addr  = v.rs1;
        deRs1Used  = v.u1;
        deRs2Addr  = v.rs2;
        deRs2Used  = v.u2;
        deRdAddr   = v.rd;
        deRegWrite = v.rw;
        deIsLoad   = v.ld;
        exRedirect = v.redir;
        memReady   = v.rdy;
        #2;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        chk({tag, ".rs1_val"}, rs1Val, v.expRs1);
        chk({tag, ".rs2_val"}, rs2Val, v.expRs2);
        chk({tag, ".stall"}, 32'(stall), 32'(v.expStall));
        chk({tag, ".freeze"}, 32'(freeze), 32'(v.expFreeze));
        chk({tag, ".flush_if"}, 32'(flushIf), 32'(v.expFlush));
        chk({tag, ".flush_de"}, 32'(flushDe), 32'(v.expFlush));
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput(v, tag);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1;
        deRs1Rf  = RF1;
        deRs2Rf  = RF2;
        stResult = {S2, S1, S0};
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RF1, RF2, 0, 0, 0));
        chk("reset.stall_forced", 32'(stall), 0);
        chk("reset.freeze_forced", 32'(freeze), 0);
        chk("reset.flush_forced", 32'(flushDe), 0);
        tick();
        tick();
        chk("reset.stall_cnt", stallCnt, 0);
        chk("reset.flush_cnt", flushCnt, 0);
        RST = 1'b0;

        // v rs1 u1 rs2 u2 rd rw ld redir rdy | rs1 rs2 stall freeze flush
        vecs[0]  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 1, RF1, RF2, 0, 0, 0);
        vecs[1]  = mk(1, 5, 1, 2, 1, 7, 1, 0, 0, 1, S0,  RF2, 0, 0, 0);
        vecs[2]  = mk(1, 5, 1, 7, 1, 0, 1, 0, 0, 1, S1,  S0,  0, 0, 0);
        vecs[3]  = mk(1, 0, 1, 5, 1, 6, 1, 1, 0, 1, RF1, S2,  0, 0, 0);
        vecs[4]  = mk(1, 7, 1, 6, 1, 8, 1, 0, 0, 1, S2,  RF2, 1, 0, 0);
        vecs[5]  = mk(1, 7, 1, 6, 1, 8, 1, 0, 0, 1, RF1, RF2, 1, 0, 0);
        vecs[6]  = mk(1, 7, 1, 6, 1, 8, 1, 0, 0, 1, RF1, S2,  0, 0, 0);
        vecs[7]  = mk(1, 8, 0, 8, 1, 9, 0, 0, 0, 1, RF1, S0,  0, 0, 0);
        vecs[8]  = mk(0, 8, 1, 0, 0, 0, 0, 0, 0, 1, S1,  RF2, 0, 0, 0);
        vecs[9]  = mk(1, 8, 1, 0, 0, 0, 1, 1, 0, 1, S2,  RF2, 0, 0, 0);
        vecs[10] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, RF1, RF2, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            runVec(vecs[i], $sformatf("row%0d", i));
        end
        chk("table.stall_cnt", stallCnt, 2);
        chk("table.flush_cnt", flushCnt, 0);

        // Redirect collides with a load-use; the load keeps moving down the pipe.
        runVec(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 1, RF1, RF2, 0, 0, 0), "redir.lw");
        runVec(mk(1, 10, 1, 0, 0, 11, 1, 0, 1, 1, RF1, RF2, 0, 0, 1), "redir.hit");
        chk("redir.flush_cnt", flushCnt, 1);
        runVec(mk(1, 10, 1, 11, 1, 0, 0, 0, 0, 1, RF1, RF2, 1, 0, 0), "redir.refetch");
        runVec(mk(1, 10, 1, 11, 1, 0, 0, 0, 0, 1, S2, RF2, 0, 0, 0), "redir.fwd");
        chk("redir.stall_cnt", stallCnt, 3);

        // Memory freeze while a dependency on entry 0 is pending.
        runVec(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 1, RF1, RF2, 0, 0, 0), "frz.add");
        runVec(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, S0, RF2, 1, 1, 0), "frz.c1");
        runVec(mk(1, 12, 1, 0, 0, 0, 0, 0, 1, 0, S0, RF2, 1, 1, 0), "frz.c2");
        runVec(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, S0, RF2, 1, 1, 0), "frz.c3");
        runVec(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 1, S0, RF2, 0, 0, 0), "frz.release");
        chk("frz.stall_cnt", stallCnt, 6);
        chk("frz.flush_cnt", flushCnt, 1);

        // Reset in the middle of a load-use stall.
        runVec(mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 1, RF1, RF2, 0, 0, 0), "rst.lw");
        applyStimulus(mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 1, RF1, RF2, 1, 0, 0));
        chk("rst.pre_stall", 32'(stall), 1);
        RST = 1'b1;
        applyStimulus(mk(1, 0, 0, 6, 1, 0, 0, 0, 1, 0, RF1, RF2, 0, 0, 0));
        chk("rst.stall", 32'(stall), 0);
        chk("rst.freeze", 32'(freeze), 0);
        chk("rst.flush_if", 32'(flushIf), 0);
        chk("rst.flush_de", 32'(flushDe), 0);
        tick();
        chk("rst.stall_cnt", stallCnt, 0);
        chk("rst.flush_cnt", flushCnt, 0);
        chk("rst.stall_cnt4", 32'(stallCnt4), 0);
        RST = 1'b0;
        runVec(mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 1, RF1, RF2, 0, 0, 0), "rst.after");

        // Twenty frozen cycles: the 4-bit counter must pin at all-ones.
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RF1, RF2, 1, 1, 0));
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("sat.stall_cnt4", 32'(stallCnt4), 15);
        chk("sat.stall_cnt", stallCnt, 20);
        chk("sat.flush_cnt4", 32'(flushCnt4), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_hazard_ctrl.md
Name: otter_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the pipelined OTTER core.
- Tracks in-flight destination registers in a DEPTH-entry scoreboard, one entry per post-decode stage.
- Selects operand bypass sources, generates load-use stalls of any load latency, and handles branch redirect flushes.
- Freezes the pipeline on a data-memory not-ready handshake. Sits beside decode; keeps saturating stall/flush performance counters.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- DEPTH, 3, tracked post-decode stages (entry 0 = EX, entry DEPTH-1 = WB); legal range 2..8.
- LOAD_STAGE, 2, lowest entry index at which load data is valid in st_result; 1 ≤ LOAD_STAGE < DEPTH.
- CNT_W, 32, performance counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- de_valid  in  1  decode holds a real (non-bubble) instruction.
- de_rs1_addr, de_rs2_addr  in  RA_W  source registers.
- de_rs1_used, de_rs2_used  in  1  source operand is actually read.
- de_rd_addr  in  RA_W  destination register.
- de_reg_write  in  1  instruction writes the regfile.
- de_is_load  in  1  instruction is a load.
- de_rs1_rf, de_rs2_rf  in  XLEN  regfile read data.
- st_result  in  DEPTH*XLEN  stage i result at [i*XLEN +: XLEN]; for loads at i ≥ LOAD_STAGE this is the load data.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_ready  in  1  data memory completes this cycle.
- rs1_val, rs2_val  out  XLEN  forwarded operands.
- stall  out  1  hold PC, IF and DE registers.
- freeze  out  1  hold all pipeline registers.
- flush_if, flush_de  out  1  squash IF and DE contents.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Scoreboard: DEPTH entries of {valid, rd, is_load}.
- On RST (synchronous): all entries invalid, both counters 0. While RST is high, stall, freeze, flush_if and flush_de are forced to 0.
- Match rule: entry i matches rsN when valid, reg_write, rd == rsN_addr, rd != 0 and rsN_used.
- Youngest match wins (lowest index).
- A match is available when !is_load or i ≥ LOAD_STAGE.
- Forwarding:
  - Available match: rsN_val = st_result slice i.
  - No match: rsN_val = de_rsN_rf.
  - Outputs are combinational, zero-cycle latency.
- load_use = de_valid and (rs1 or rs2 youngest match unavailable).
- freeze = !mem_ready. When freeze is high:
  - scoreboard holds;
  - stall = 1;
  - flush outputs = 0. The redirect is re-evaluated once the freeze releases, and EX holds the redirect.
- Priority when not frozen: ex_redirect > load_use.
  - ex_redirect: flush_if = flush_de = 1, stall = 0, entry 0 ← bubble.
  - load_use: stall = 1, entry 0 ← bubble, DE held.
  - Otherwise: entry 0 ← {de_valid & de_reg_write, de_rd_addr, de_is_load}.
- Shift: entry i ← entry i-1 for i ≥ 1 on every non-frozen cycle. Entry DEPTH-1 retires.
- A load with LOAD_STAGE = L stalls a dependent next instruction exactly L cycles, or fewer if the dependency is further back.
- Counters increment by 1 per cycle in which stall (load_use or freeze) or flush_de is asserted, respectively. They saturate at all-ones with no wrap.
- Write to x0 never forwards and never stalls.
- Redirect while a load is in flight: the load entry keeps shifting; only DE/IF are squashed.

Decomposition:
- Shared package otter_pipe_pkg holds:
  - typedef sb_entry_t {valid, rd, is_load};
  - typedef fwd_sel_t;
  - the opcode_t enum, for the caller's de_is_load / de_reg_write decode.
- One sub-module, otter_fwd_select: purely combinational priority match of one operand over the scoreboard. It returns {hit, available, index}, is instantiated twice, and keeps the top-level free of per-operand loops.

Test Plan:
- Back-to-back ALU dependence:
  - Stimulus: cycle 0 issues add x5 (rd=5). Cycle 1 decodes sub, rs1=5, with st_result[0]=0x11.
  - Required response: rs1_val=0x11, stall=0.
- Load-use, DEPTH=3, LOAD_STAGE=2:
  - Stimulus: lw x6, then add rs2=6.
  - Required response: stall=1 for 2 cycles, stall_cnt=2. Then rs2_val = st_result[2] slice = 0xDEADBEEF.
- Stimulus: x0 dependency, lw x0 then use rs1=0 -> required response: stall=0, rs1_val=de_rs1_rf.
- Redirect during load-use:
  - Stimulus: ex_redirect=1 and load_use true in the same cycle.
  - Required response: flush_if=flush_de=1, stall=0, flush_cnt=1, entry 0 becomes a bubble.
- Freeze:
  - Stimulus: mem_ready=0 for 3 cycles during a pending dependency.
  - Required response: freeze=stall=1, scoreboard unchanged, forwarding index unchanged after release, stall_cnt+=3.
- Reset and saturation:
  - Stimulus: RST mid-stall.
  - Required response: next cycle all outputs 0, counters 0. Separately, with CNT_W=4, 20 stall cycles give stall_cnt=15.
